// File: rtl/cus_mac_seq_pkg.sv
// Shared definitions for the iterative multiply-accumulate sequencer:
// FSM state encodings, the custom opcode and the default step width.
package cus_mac_seq_pkg;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RUN  = 2'd1,
    MAC_DONE = 2'd2
  } mac_state_e;

  // Major opcode of the custom MAC instruction (decoded upstream into start)
  localparam logic [6:0] CUS_OPCODE = 7'b0001011;

  // Multiplier bits retired per RUN cycle; must divide 32
  localparam int STEP_BITS_DEF = 2;

  // Counter wide enough to hold STEPS for STEP_BITS=1 (32)
  localparam int CNT_W = 6;

  function automatic int steps_of(input int step_bits);
    return 32 / step_bits;
  endfunction

endpackage

// File: rtl/cus_mac_seq_if.sv
// Pipeline-facing bundle of the MAC sequencer: operands and control in,
// stall/handshake and result out.
interface cus_mac_seq_if;
  logic        start;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_acc;
  logic [4:0]  op_rd;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  // Pipeline / execute-stage side
  modport master (
    output start, flush, op_a, op_b, op_acc, op_rd,
    input  stall_req, busy, done, result, result_rd
  );

  // Sequencer side
  modport slave (
    input  start, flush, op_a, op_b, op_acc, op_rd,
    output stall_req, busy, done, result, result_rd
  );
endinterface

// File: rtl/cus_mac_seq_mac_step.sv
// One shift-add step: adds multiplicand times the low STEP_BITS multiplier
// digit into the accumulator and shifts both operand registers.
module mac_step #(
  parameter int STEP_BITS = 2
) (
  input  logic [31:0] acc_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic [31:0] acc_o,
  output logic [31:0] mcand_o,
  output logic [31:0] mplier_o
);

  logic [31:0] digit;

  // Zero-extended multiplier digit; product keeps only the low 32 bits
  assign digit    = 32'(mplier_i[STEP_BITS-1:0]);
  assign acc_o    = acc_i + mcand_i * digit;
  assign mcand_o  = mcand_i << STEP_BITS;
  assign mplier_o = mplier_i >> STEP_BITS;

endmodule

// File: rtl/cus_mac_seq.sv
// Multi-cycle sequencer for the custom MAC instruction (rd = rs1*rs2 + rd,
// low 32 bits). Holds the pipeline stall while the op iterates and presents
// the result for one cycle in DONE.
// Build option: CUS_MAC_EARLY_EXIT_EN ends RUN as soon as the remaining
// multiplier bits are all zero; results are unchanged, only latency.
module cus_mac_seq
  import cus_mac_seq_pkg::*;
#(
  parameter int STEP_BITS = STEP_BITS_DEF
) (
  input  logic CLK,
  input  logic RES,
  cus_mac_seq_if.slave bus
);

  localparam int STEPS = 32 / STEP_BITS;

  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [31:0]      acc_q, acc_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      res_hold_q;
  logic [4:0]       rd_hold_q;

  logic [31:0] acc_nx, mcand_nx, mplier_nx;
  logic        load, done_w;

  mac_step #(.STEP_BITS(STEP_BITS)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nx),
    .mcand_o  (mcand_nx),
    .mplier_o (mplier_nx)
  );

  // Next-state, operand loading and iteration control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    load     = 1'b0;
    case (state_q)
      MAC_IDLE: if (!bus.flush && bus.start) load = 1'b1;
      MAC_RUN: begin
        if (bus.flush) begin
          state_d = MAC_IDLE;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_nx;
          mplier_d = mplier_nx;
          cnt_d    = cnt_q - 1'b1;
`ifdef CUS_MAC_EARLY_EXIT_EN
          if (cnt_q == CNT_W'(1) || mplier_nx == 32'd0) state_d = MAC_DONE;
`else
          if (cnt_q == CNT_W'(1)) state_d = MAC_DONE;
`endif
        end
      end
      MAC_DONE: begin
        if (bus.flush)      state_d = MAC_IDLE;
        else if (bus.start) load    = 1'b1;
        else                state_d = MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
    // New op: from IDLE or back-to-back out of DONE
    if (load) begin
      mcand_d  = bus.op_a;
      mplier_d = bus.op_b;
      acc_d    = bus.op_acc;
      rd_d     = bus.op_rd;
      cnt_d    = CNT_W'(STEPS);
      state_d  = MAC_RUN;
    end
  end

  // State, datapath and held-result registers
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q    <= MAC_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      rd_q       <= '0;
      res_hold_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      if (done_w) begin
        res_hold_q <= acc_q;
        rd_hold_q  <= rd_q;
      end
    end
  end

  // Outputs: result is live in the retiring cycle, held afterwards
  assign done_w        = (state_q == MAC_DONE) && !bus.flush && !RES;
  assign bus.done      = done_w;
  assign bus.busy      = (state_q == MAC_RUN);
  assign bus.result    = done_w ? acc_q : res_hold_q;
  assign bus.result_rd = done_w ? rd_q : rd_hold_q;
  assign bus.stall_req = !RES && ((state_q == MAC_RUN) ||
                         (state_q != MAC_RUN && bus.start && !bus.flush));

endmodule

// File: tb/tb_cus_mac_seq.sv
// Directed bench for the MAC sequencer (STEP_BITS=2, 16 RUN cycles).
module tb_cus_mac_seq;

  logic clk, res;
  int   total, bad;

  cus_mac_seq_if bus();

  cus_mac_seq #(.STEP_BITS(2)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CUS_MAC_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 17;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op with a single-cycle start; returns cycles from start to done
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [4:0] rd,
                        output int lat, output int stl,
                        output logic [31:0] r, output logic [4:0] rrd);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.op_acc = c; bus.op_rd = rd;
    bus.start = 1'b1;
    lat = -1; stl = 0; r = 'x; rrd = 'x;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      #1;
      if (bus.stall_req) stl++;
      if (bus.done) begin
        lat = k; r = bus.result; rrd = bus.result_rd;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  int          lat, stl, lat2, dcnt;
  logic [31:0] r;
  logic [4:0]  rrd;

  initial begin
    total = 0; bad = 0;
    res = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.op_acc = '0; bus.op_rd = '0;
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1;
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd", 32'(bus.result_rd), 32'd0);

    // Basic op: 3*5+7
    run_op(32'd3, 32'd5, 32'd7, 5'd12, lat, stl, r, rrd);
    chk("basic_lat", 32'(lat), 32'd17);
    chk("basic_stall", 32'(stl), 32'd17);
    chk("basic_res", r, 32'd22);
    chk("basic_rd", 32'(rrd), 32'd12);
    @(negedge clk); #1;
    chk("hold_done", 32'(bus.done), 32'd0);
    chk("hold_res", bus.result, 32'd22);
    chk("hold_rd", 32'(bus.result_rd), 32'd12);

    // Wraparound cases
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd1, lat, stl, r, rrd);
    chk("ovf1_lat", 32'(lat), 32'd17);
    chk("ovf1_res", r, 32'h0000_0001);
    run_op(32'h8000_0000, 32'd2, 32'd5, 5'd2, lat, stl, r, rrd);
    chk("ovf2_res", r, 32'h0000_0005);

    // Back-to-back: start held through DONE with new operands
    @(negedge clk);
    bus.op_a = 32'd3; bus.op_b = 32'd5; bus.op_acc = 32'd7; bus.op_rd = 5'd4;
    bus.start = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (bus.done) begin lat = k; break; end
    end
    chk("b2b_lat1", 32'(lat), 32'd17);
    chk("b2b_res1", bus.result, 32'd22);
    chk("b2b_stall_done", 32'(bus.stall_req), 32'd1);
    bus.op_a = 32'd4; bus.op_b = 32'd4; bus.op_acc = 32'd1; bus.op_rd = 5'd9;
    lat2 = -1;
    for (int j = 1; j < 40; j++) begin
      @(negedge clk);
      if (j == 1) bus.start = 1'b0;
      #1;
      if (j == 1) chk("b2b_no_idle", 32'(bus.busy), 32'd1);
      if (bus.done) begin lat2 = j; break; end
    end
    chk("b2b_lat2", 32'(lat2), 32'd17);
    chk("b2b_res2", bus.result, 32'd17);
    chk("b2b_rd2", 32'(bus.result_rd), 32'd9);

    // Flush in the 5th RUN cycle
    @(negedge clk);
    bus.op_a = 32'd9; bus.op_b = 32'd9; bus.op_acc = 32'd9; bus.op_rd = 5'd3;
    bus.start = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) bus.flush = 1'b1;
      if (k == 6) bus.flush = 1'b0;
      #1;
      if (bus.done) dcnt++;
      if (k == 5) chk("flush_busy_before", 32'(bus.busy), 32'd1);
      if (k == 6) begin
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_stall", 32'(bus.stall_req), 32'd0);
      end
    end
    chk("flush_no_done", 32'(dcnt), 32'd0);
    run_op(32'd2, 32'd3, 32'd0, 5'd7, lat, stl, r, rrd);
    chk("postflush_lat", 32'(lat), 32'd17);
    chk("postflush_res", r, 32'd6);

    // Reset mid-RUN
    @(negedge clk);
    bus.op_a = 32'd1; bus.op_b = 32'd1; bus.op_acc = 32'd1; bus.op_rd = 5'd1;
    bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) res = 1'b1;
      #1;
      if (k == 5) chk("rstmid_stall_same", 32'(bus.stall_req), 32'd0);
    end
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_stall", 32'(bus.stall_req), 32'd0);
    chk("rstmid_result", bus.result, 32'd0);
    chk("rstmid_rd", 32'(bus.result_rd), 32'd0);

    // Early-exit candidates (latency depends on build)
    run_op(32'd7, 32'd3, 32'd1, 5'd5, lat, stl, r, rrd);
    chk("early3_lat", 32'(lat), 32'(EARLY_LAT));
    chk("early3_res", r, 32'd22);
    run_op(32'd5, 32'd0, 32'd9, 5'd6, lat, stl, r, rrd);
    chk("early0_lat", 32'(lat), 32'(EARLY_LAT));
    chk("early0_res", r, 32'd9);
    chk("early0_rd", 32'(rrd), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
